// File: rtl/ir_receiver_bus_if.sv
// IR command receiver on the 8-bit processor bus.
// Times the synchronised IR envelope, decodes a start burst plus six data
// bursts (car[1:0], right, left, backward, forward), latches each frame into
// COMMAND, and raises an interrupt. STATUS = {5'b0, FERR, OVR, VALID}.
module ir_receiver_bus_if #(
    parameter logic [7:0]  BASE_ADDR   = 8'h98,
    parameter int unsigned START_MIN   = 150000,
    parameter int unsigned ONE_MIN     = 60000,
    parameter int unsigned ZERO_MIN    = 20000,
    parameter int unsigned GAP_TIMEOUT = 200000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       IR_IN,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam logic [7:0]       CMD_ADDR      = BASE_ADDR + 8'd1;
    localparam logic [CNT_W-1:0] START_MIN_C   = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] ONE_MIN_C     = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] ZERO_MIN_C    = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] GAP_TIMEOUT_C = CNT_W'(GAP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO      = '0;
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONES      = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_BIT
    } state_t;

    // Input synchroniser
    logic ir_meta;
    logic ir_sync;

    // Decoder state
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitcnt;
    logic [4:0]       shift;

    // Registers and bus read path
    logic [7:0] command;
    logic       valid;
    logic       ovr;
    logic       ferr;
    logic       rd_oe;
    logic [7:0] rd_data;

    // Combinational decode
    logic [CNT_W-1:0] cnt_inc;
    logic             bit_val;
    logic             burst_short;
    logic             commit;
    logic             ferr_set;
    logic [5:0]       frame;
    logic             rd_status;
    logic             rd_command;
    logic             wr_status;
    logic             clr_ovr;
    logic             clr_ferr;

    // Two-flop synchroniser for the asynchronous IR envelope
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: non-blocking assignments so ir_sync takes the pre-edge ir_meta, giving two real stages.
        if (RESET) begin
            ir_meta <= 1'b0;
            ir_sync <= 1'b0;
        end else begin
            ir_meta <= IR_IN;
            ir_sync <= ir_meta;
        end
    end

    // Burst classification, frame events and bus address decode
    always_comb begin
        // NOTE: every signal assigned unconditionally here, so no latch can be inferred.
        cnt_inc     = (cnt == CNT_ONES) ? cnt : cnt + CNT_ONE;
        bit_val     = (cnt >= ONE_MIN_C);
        burst_short = (cnt < ZERO_MIN_C);
        frame       = {shift, bit_val};
        commit      = (state == S_BIT) && !ir_sync && !burst_short && (bitcnt == 3'd5);
        ferr_set    = ((state == S_GAP) && !ir_sync && (cnt_inc >= GAP_TIMEOUT_C)) ||
                      ((state == S_BIT) && !ir_sync && burst_short);
        rd_status   = (BUS_ADDR == BASE_ADDR) && !BUS_WE;
        rd_command  = (BUS_ADDR == CMD_ADDR) && !BUS_WE;
        wr_status   = (BUS_ADDR == BASE_ADDR) && BUS_WE;
        clr_ovr     = wr_status && (|(BUS_DATA & 8'h02));
        clr_ferr    = wr_status && (|(BUS_DATA & 8'h04));
    end

    // Frame decoder: times high bursts and low gaps, shifts in data bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            cnt    <= CNT_ZERO;
            bitcnt <= 3'd0;
            shift  <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ir_sync) begin
                        state <= S_START;
                        cnt   <= CNT_ONE;
                    end
                end
                S_START: begin
                    if (ir_sync) begin
                        cnt <= cnt_inc;
                    end else if (cnt >= START_MIN_C) begin
                        state  <= S_GAP;
                        bitcnt <= 3'd0;
                        cnt    <= CNT_ZERO;
                    end else begin
                        // Too short for a start: treat as noise, no error.
                        state <= S_IDLE;
                        cnt   <= CNT_ZERO;
                    end
                end
                S_GAP: begin
                    if (ir_sync) begin
                        state <= S_BIT;
                        cnt   <= CNT_ONE;
                    end else if (ferr_set) begin
                        state <= S_IDLE;
                        cnt   <= CNT_ZERO;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_BIT: begin
                    if (ir_sync) begin
                        cnt <= cnt_inc;
                        // A burst as long as a start restarts the frame; the
                        // count carries on in START.
                        if (cnt_inc >= START_MIN_C) begin
                            state <= S_START;
                        end
                    end else if (burst_short) begin
                        state <= S_IDLE;
                        cnt   <= CNT_ZERO;
                    end else begin
                        shift <= frame[4:0];
                        cnt   <= CNT_ZERO;
                        if (bitcnt == 3'd5) begin
                            state  <= S_IDLE;
                            bitcnt <= 3'd0;
                        end else begin
                            state  <= S_GAP;
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    // COMMAND/STATUS flags and interrupt; frame events take priority over bus clears
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            command             <= 8'h00;
            valid               <= 1'b0;
            ovr                 <= 1'b0;
            ferr                <= 1'b0;
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            if (commit) begin
                command <= {2'b00, frame};
            end

            if (commit) begin
                valid <= 1'b1;
            end else if (rd_command) begin
                valid <= 1'b0;
            end

            if (commit && valid) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end

            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (clr_ferr) begin
                ferr <= 1'b0;
            end

            if (commit) begin
                BUS_INTERRUPT_RAISE <= 1'b1;
            end else if (BUS_INTERRUPT_ACK) begin
                BUS_INTERRUPT_RAISE <= 1'b0;
            end
        end
    end

    // Registered read: data captured on the addressing edge, driven for one cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_oe   <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rd_oe <= rd_status || rd_command;
            if (rd_status) begin
                rd_data <= {5'b00000, ferr, ovr, valid};
            end else if (rd_command) begin
                rd_data <= command;
            end else begin
                rd_data <= 8'h00;
            end
        end
    end

    assign BUS_DATA = rd_oe ? rd_data : 8'hzz;

endmodule

// File: tb/tb_ir_receiver_bus_if.sv
// Directed bench for ir_receiver_bus_if with shortened burst timings.
module tb_ir_receiver_bus_if;

    logic       CLK;
    logic       RESET;
    tri1  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       IR_IN;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    logic       tb_oe;
    logic [7:0] tb_wdata;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [5:0] bits;
        int         start_len;
        int         one_len;
        int         zero_len;
        int         gap_len;
        logic [7:0] exp_cmd;
    } vec_t;

    vec_t vecs[5];

    assign BUS_DATA = tb_oe ? tb_wdata : 8'hzz;

    ir_receiver_bus_if #(
        .BASE_ADDR  (8'h98),
        .START_MIN  (30),
        .ONE_MIN    (12),
        .ZERO_MIN   (4),
        .GAP_TIMEOUT(40),
        .CNT_W      (20)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .BUS_DATA           (BUS_DATA),
        .BUS_ADDR           (BUS_ADDR),
        .BUS_WE             (BUS_WE),
        .IR_IN              (IR_IN),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Hold IR_IN at v for n sampling edges; returns 1 time unit after an edge.
    task automatic ir_level(input logic v, input int n);
        IR_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [5:0] bits, input int one_len, input int zero_len,
                             input int gap_len);
        for (int i = 5; i >= 0; i--) begin
            ir_level(1'b0, gap_len);
            ir_level(1'b1, bits[i] ? one_len : zero_len);
        end
    endtask

    // Whole frame except the final falling edge.
    task automatic send_frame_open(input logic [5:0] bits, input int start_len, input int one_len,
                                   input int zero_len, input int gap_len);
        ir_level(1'b1, start_len);
        send_bits(bits, one_len, zero_len, gap_len);
    endtask

    task automatic send_frame(input logic [5:0] bits);
        send_frame_open(bits, 35, 14, 6, 10);
        ir_level(1'b0, 12);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        @(posedge CLK);
        #1;
        data     = BUS_DATA;
        BUS_ADDR = 8'h00;
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        BUS_ADDR = addr;
        BUS_WE   = 1'b1;
        tb_wdata = data;
        tb_oe    = 1'b1;
        @(posedge CLK);
        #1;
        tb_oe    = 1'b0;
        BUS_WE   = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic ack_pulse();
        BUS_INTERRUPT_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b0;
    endtask

    initial begin
        logic [7:0] d;

        vecs[0] = '{bits: 6'b100101, start_len: 35, one_len: 14, zero_len: 6,  gap_len: 10, exp_cmd: 8'h25};
        vecs[1] = '{bits: 6'b111111, start_len: 35, one_len: 12, zero_len: 4,  gap_len: 10, exp_cmd: 8'h3F};
        vecs[2] = '{bits: 6'b000000, start_len: 35, one_len: 12, zero_len: 4,  gap_len: 10, exp_cmd: 8'h00};
        vecs[3] = '{bits: 6'b101010, start_len: 30, one_len: 12, zero_len: 11, gap_len: 10, exp_cmd: 8'h2A};
        vecs[4] = '{bits: 6'b010110, start_len: 60, one_len: 20, zero_len: 5,  gap_len: 40, exp_cmd: 8'h16};

        RESET             = 1'b1;
        IR_IN             = 1'b0;
        BUS_ADDR          = 8'h00;
        BUS_WE            = 1'b0;
        BUS_INTERRUPT_ACK = 1'b0;
        tb_oe             = 1'b0;
        tb_wdata          = 8'h00;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        check("rst_bus_hiz", BUS_DATA, 8'hFF);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        bus_read(8'h98, d);
        check("rst_status", d, 8'h00);
        bus_read(8'h99, d);
        check("rst_command", d, 8'h00);
        check("idle_bus_hiz", BUS_DATA, 8'hFF);

        // Table-driven frames, including exact-threshold bursts and the longest legal gap
        for (int i = 0; i < 5; i++) begin
            send_frame_open(vecs[i].bits, vecs[i].start_len, vecs[i].one_len,
                            vecs[i].zero_len, vecs[i].gap_len);
            ir_level(1'b0, 12);
            check($sformatf("vec%0d_raise", i), {7'd0, BUS_INTERRUPT_RAISE}, 8'h01);
            bus_read(8'h98, d);
            check($sformatf("vec%0d_status", i), d, 8'h01);
            bus_read(8'h99, d);
            check($sformatf("vec%0d_command", i), d, vecs[i].exp_cmd);
            bus_read(8'h98, d);
            check($sformatf("vec%0d_status_after_read", i), d, 8'h00);
            ack_pulse();
            check($sformatf("vec%0d_raise_after_ack", i), {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        end

        // Reset in the middle of a burst discards everything
        send_frame(6'b110110);
        ir_level(1'b1, 35);
        ir_level(1'b0, 10);
        ir_level(1'b1, 8);
        RESET = 1'b1;
        #2;
        check("midreset_raise_async", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ir_level(1'b1, 6);
        ir_level(1'b0, 12);
        check("midreset_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        bus_read(8'h98, d);
        check("midreset_status", d, 8'h00);
        bus_read(8'h99, d);
        check("midreset_command", d, 8'h00);

        // Short "start" and following bursts are noise: no commit, no error
        ir_level(1'b1, 20);
        ir_level(1'b0, 10);
        send_bits(6'b111111, 14, 6, 10);
        ir_level(1'b0, 12);
        check("noise_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        bus_read(8'h98, d);
        check("noise_status", d, 8'h00);

        // 3-cycle burst mid-frame is a frame error
        ir_level(1'b1, 35);
        ir_level(1'b0, 10);
        ir_level(1'b1, 14);
        ir_level(1'b0, 10);
        ir_level(1'b1, 3);
        ir_level(1'b0, 12);
        check("short_burst_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h00);
        bus_read(8'h98, d);
        check("short_burst_status", d, 8'h04);
        bus_write(8'h98, 8'h04);
        bus_read(8'h98, d);
        check("ferr_cleared", d, 8'h00);

        // 41-cycle gap after two bits is a frame error; only bit2 clears FERR
        ir_level(1'b1, 35);
        ir_level(1'b0, 10);
        ir_level(1'b1, 14);
        ir_level(1'b0, 10);
        ir_level(1'b1, 6);
        ir_level(1'b0, 46);
        bus_read(8'h98, d);
        check("gap_timeout_status", d, 8'h04);
        bus_write(8'h98, 8'h02);
        bus_read(8'h98, d);
        check("ferr_kept_by_ovr_clear", d, 8'h04);
        bus_write(8'h98, 8'h04);
        bus_read(8'h98, d);
        check("gap_ferr_cleared", d, 8'h00);

        // Overrun, with ACK landing on the second commit edge
        send_frame(6'b100101);
        check("ovr_first_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h01);
        send_frame_open(6'b011010, 35, 14, 6, 10);
        IR_IN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b0;
        check("ack_on_commit_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h01);
        ir_level(1'b0, 8);
        bus_read(8'h98, d);
        check("ovr_status", d, 8'h03);
        bus_write(8'h98, 8'h02);
        bus_read(8'h98, d);
        check("ovr_cleared_status", d, 8'h01);
        bus_read(8'h99, d);
        check("ovr_command", d, 8'h1A);
        ack_pulse();

        // COMMAND read on the commit edge: old data returned, VALID stays set
        send_frame_open(6'b110011, 35, 14, 6, 10);
        IR_IN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        BUS_ADDR = 8'h99;
        BUS_WE   = 1'b0;
        @(posedge CLK);
        #1;
        d        = BUS_DATA;
        BUS_ADDR = 8'h00;
        check("read_on_commit_old_data", d, 8'h1A);
        ir_level(1'b0, 8);
        bus_write(8'h99, 8'hFF);
        bus_read(8'h98, d);
        check("read_on_commit_valid", d, 8'h01);
        bus_read(8'h99, d);
        check("read_on_commit_new_cmd", d, 8'h33);
        ack_pulse();

        // A start-length burst inside BIT restarts the frame
        ir_level(1'b1, 35);
        ir_level(1'b0, 10);
        ir_level(1'b1, 14);
        ir_level(1'b0, 10);
        ir_level(1'b1, 30);
        send_bits(6'b011100, 14, 6, 10);
        ir_level(1'b0, 12);
        check("restart_raise", {7'd0, BUS_INTERRUPT_RAISE}, 8'h01);
        bus_read(8'h98, d);
        check("restart_status", d, 8'h01);
        bus_read(8'h99, d);
        check("restart_command", d, 8'h1C);
        ack_pulse();
        check("final_bus_hiz", BUS_DATA, 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
